// File: rtl/fourmux32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fourmux32_rr_arbiter
//   Round-robin arbiter that shares one 32-bit four-way mux (fourmux32)
//   between four requesters. The grant and mux select are registered; the
//   selected requester's data word appears on Y combinationally.
//
//   Optional feature macro: ARB_HOLD_LIMIT_EN
//     defined   - an owner that has held the grant HOLD_MAX cycles is
//                 preempted when any other requester is waiting.
//     undefined - no hold counter; the owner keeps the grant until it
//                 drops its request.
//
// Ports
//   CLK    in   1   rising-edge clock
//   RST_N  in   1   asynchronous active-low reset
//   REQ    in   4   level requests, bit i = requester i
//   D0..D3 in   32  requester data words
//   GNT    out  4   registered one-hot grant, zero when idle
//   S      out  2   registered mux select (index of the GNT bit)
//   Y      out  32  D[S]; meaningful while VALID=1
//   VALID  out  1   |GNT
// ---------------------------------------------------------------------------

// Plain four-way 32-bit mux shared by the requesters.
module fourmux32 (
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [31:0] D3,
  input  logic [1:0]  S,
  output logic [31:0] Y
);
  always_comb begin
    unique case (S)
      2'd0:    Y = D0;
      2'd1:    Y = D1;
      2'd2:    Y = D2;
      default: Y = D3;
    endcase
  end
endmodule

module fourmux32_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REQ,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [31:0] D3,
  output logic [3:0]  GNT,
  output logic [1:0]  S,
  output logic [31:0] Y,
  output logic        VALID
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic [1:0] last_q, last_d;
  logic [1:0] winner;
  logic       load;

`ifdef ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             others_waiting;
  logic             hold_expired;
`endif

  // First requester found searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(REQ, last_q);

`ifdef ARB_HOLD_LIMIT_EN
  assign others_waiting = |(REQ & ~gnt_q);
  // The count is zero during the first granted cycle, so HOLD_MAX-1 at an
  // edge means the owner has already used HOLD_MAX cycles.
  assign hold_expired   = (cnt_q >= CNT_W'(HOLD_MAX - 1));
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    last_d  = last_q;
    load    = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|REQ) load = 1'b1;
      end
      default: begin
        if (REQ[s_q]) begin
`ifdef ARB_HOLD_LIMIT_EN
          if (hold_expired && others_waiting) begin
            // Owner is k = last_q, so the search reaches every other
            // requester before wrapping back to k.
            load = 1'b1;
          end else if (cnt_q < CNT_W'(HOLD_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end else if (|REQ) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
    endcase

    if (load) begin
      state_d = GRANT;
      gnt_d   = 4'(1) << winner;
      s_d     = winner;
      last_d  = winner;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_d   = '0;
`endif
    end

`ifdef ARB_HOLD_LIMIT_EN
    if (state_d == IDLE) cnt_d = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= 2'd0;
      last_q  <= 2'd3;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      last_q  <= last_d;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign S     = s_q;
  assign VALID = |gnt_q;

  fourmux32 u_mux (
    .D0 (D0),
    .D1 (D1),
    .D2 (D2),
    .D3 (D3),
    .S  (s_q),
    .Y  (Y)
  );

endmodule

// File: tb/tb_fourmux32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fourmux32_rr_arbiter
//   Directed scoreboard bench for fourmux32_rr_arbiter. The stimulus process
//   pushes the hand-computed expected grant after each edge; a monitor on
//   the falling edge pops and compares GNT, S, VALID and Y.
// ---------------------------------------------------------------------------
module tb_fourmux32_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] D0, D1, D2, D3;
  logic [3:0]  GNT;
  logic [1:0]  S;
  logic [31:0] Y;
  logic        VALID;

  typedef struct {
    string       name;
    logic [3:0]  gnt;
    logic [1:0]  s;
    logic [31:0] y;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dw[4];
  int          total = 0;
  int          bad   = 0;

  always #5 CLK = ~CLK;

  fourmux32_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .D0    (D0),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .GNT   (GNT),
    .S     (S),
    .Y     (Y),
    .VALID (VALID)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply REQ, take one rising edge, then queue the expected registered result.
  task automatic step(input string name, input logic [3:0] req,
                      input logic [3:0] eg, input logic [1:0] es);
    exp_t e;
    REQ = req;
    @(posedge CLK);
    #1;
    e.name = name;
    e.gnt  = eg;
    e.s    = es;
    e.y    = dw[es];
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".gnt"},   32'(GNT),   32'(e.gnt));
      check({e.name, ".valid"}, 32'(VALID), 32'(|e.gnt));
      if (e.gnt != 4'b0000) begin
        check({e.name, ".s"}, 32'(S), 32'(e.s));
        check({e.name, ".y"}, Y, e.y);
      end
    end
  end

  initial begin
    dw[0] = 32'h0000_1111;
    dw[1] = 32'h2222_0000;
    dw[2] = 32'hA5A5_A5A5;
    dw[3] = 32'h3C3C_C3C3;
    D0 = dw[0]; D1 = dw[1]; D2 = dw[2]; D3 = dw[3];

    // Reset with all requests pending: nothing granted, Y shows D0.
    RST_N = 1'b0;
    REQ   = 4'b1111;
    #2;
    check("rst.gnt",   32'(GNT),   32'h0);
    check("rst.valid", 32'(VALID), 32'h0);
    check("rst.s",     32'(S),     32'h0);
    check("rst.y",     Y,          dw[0]);
    @(negedge CLK);
    check("rst_hold.gnt", 32'(GNT), 32'h0);
    #1 RST_N = 1'b1;

    // LAST=3 after reset, so REQ=1111 grants 0 first; round robin 0,1,2,3,0.
    step("rr0a", 4'b1111, 4'b0001, 2'd0);
    step("rr0b", 4'b1111, 4'b0001, 2'd0);
    step("rr1a", 4'b1110, 4'b0010, 2'd1);
    step("rr1b", 4'b1111, 4'b0010, 2'd1);
    step("rr2a", 4'b1101, 4'b0100, 2'd2);
    step("rr2b", 4'b1111, 4'b0100, 2'd2);
    step("rr3a", 4'b1011, 4'b1000, 2'd3);
    step("rr3b", 4'b1111, 4'b1000, 2'd3);
    step("rr0c", 4'b0111, 4'b0001, 2'd0);
    step("idle0", 4'b0000, 4'b0000, 2'd0);

    // Single requester 2 held five edges, then released.
    for (int i = 0; i < 5; i++) step("single", 4'b0100, 4'b0100, 2'd2);
    step("single_drop", 4'b0000, 4'b0000, 2'd0);
    step("idle1",       4'b0000, 4'b0000, 2'd0);

    // Owner 1 holds while requester 3 toggles; grant must not move.
    step("noise0", 4'b0010, 4'b0010, 2'd1);
    step("noise1", 4'b1010, 4'b0010, 2'd1);
    step("noise2", 4'b0010, 4'b0010, 2'd1);
    step("noise3", 4'b1010, 4'b0010, 2'd1);

    // Owner 1 drops with 3 waiting: regrant to 3 with no bubble.
    step("to3", 4'b1000, 4'b1000, 2'd3);

    // Asynchronous reset between edges clears the grant at once.
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst.gnt",   32'(GNT),   32'h0);
    check("async_rst.valid", 32'(VALID), 32'h0);
    check("async_rst.s",     32'(S),     32'h0);
    #1 RST_N = 1'b1;
    step("post_rst", 4'b1001, 4'b0001, 2'd0);
    step("idle2",    4'b0000, 4'b0000, 2'd0);

    // Set LAST=3 again so the hold test starts with requester 0.
    step("prime3", 4'b1000, 4'b1000, 2'd3);
    step("idle3",  4'b0000, 4'b0000, 2'd0);
`ifdef ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 4; i++) step("hold_a", 4'b0011, 4'b0001, 2'd0);
    for (int i = 0; i < 4; i++) step("hold_b", 4'b0011, 4'b0010, 2'd1);
    for (int i = 0; i < 4; i++) step("hold_c", 4'b0011, 4'b0001, 2'd0);
`else
    for (int i = 0; i < 12; i++) step("hold", 4'b0011, 4'b0001, 2'd0);
`endif
    step("idle4", 4'b0000, 4'b0000, 2'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
